pc_sequencer: RTL and testbench

Parametrised program-counter unit for the RISC-V core's fetch stage. It holds the PC in a register and selects the next PC each cycle: sequential +4/+2 (compressed), taken branch/jump, or trap vector. It also handles fetch stall, halt, post-redirect bubble insertion and misaligned-target detection. It sits between the branch/exception logic and the instruction-memory address port, and its PCnext output replaces the standalone PC adder.

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential stepping, branch/trap redirect,
// post-redirect bubbles, halt, and misaligned-target reporting.
module pc_sequencer #(
  parameter int unsigned        BITSIZE       = 32,
  parameter logic [BITSIZE-1:0] RESET_VECTOR  = '0,
  parameter bit                 C_EXT         = 1'b1,
  parameter int unsigned        BUBBLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Stall,
  input  logic               Compressed,
  input  logic               BranchTaken,
  input  logic [BITSIZE-1:0] BranchTarget,
  input  logic               Trap,
  input  logic [BITSIZE-1:0] TrapVector,
  input  logic               Halt,
  output logic [BITSIZE-1:0] PC,
  output logic [BITSIZE-1:0] PCnext,
  output logic               PCvalid,
  output logic               MisalignedErr,
  output logic [BITSIZE-1:0] MisalignedAddr
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_BUBBLE,
    S_HALT
  } state_e;

  localparam logic [3:0] BUBBLE_LOAD = 4'(BUBBLE_CYCLES);

  state_e             state_q, state_d;
  logic [BITSIZE-1:0] pc_q, pc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [BITSIZE-1:0] addr_q, addr_d;

  logic [BITSIZE-1:0] step;
  logic [BITSIZE-1:0] trap_target;
  logic               target_misaligned;

  assign step              = (C_EXT && Compressed) ? BITSIZE'(2) : BITSIZE'(4);
  assign trap_target       = TrapVector & {{(BITSIZE-2){1'b1}}, 2'b00};
  assign target_misaligned = BranchTarget[0] | (~C_EXT & BranchTarget[1]);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        pc_d    = RESET_VECTOR;
      end
      S_HALT: begin
        // Branches are ignored while halted; a trap still moves the PC.
        if (Trap) begin
          pc_d = trap_target;
        end else if (!Halt) begin
          state_d = S_BUBBLE;
          cnt_d   = BUBBLE_LOAD;
        end
      end
      default: begin
        if (Trap) begin
          pc_d    = trap_target;
          cnt_d   = BUBBLE_LOAD;
          state_d = Halt ? S_HALT : S_BUBBLE;
        end else if (Halt) begin
          state_d = S_HALT;
        end else if (BranchTaken) begin
          pc_d    = target_misaligned ? trap_target : BranchTarget;
          err_d   = target_misaligned;
          addr_d  = target_misaligned ? BranchTarget : addr_q;
          cnt_d   = BUBBLE_LOAD;
          state_d = S_BUBBLE;
        end else if (state_q == S_BUBBLE) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = S_RUN;
        end else if (!Stall) begin
          pc_d = PCnext;
        end
      end
    endcase
    valid_d = (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  assign PC             = pc_q;
  assign PCnext         = pc_q + step;
  assign PCvalid        = valid_q;
  assign MisalignedErr  = err_q;
  assign MisalignedAddr = addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: two instances (C_EXT=1/BUBBLE=1 and
// C_EXT=0/BUBBLE=3) share stimulus, each checked against its own model.
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcn;
    logic        v;
    logic        e;
    logic [31:0] addr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, comp = 1'b0, bt = 1'b0, trap = 1'b0, halt = 1'b0;
  logic [31:0] target = '0, tv = '0;

  logic [31:0] pc_c, pcn_c, a_c, pc_n, pcn_n, a_n;
  logic        v_c, e_c, v_n, e_n;

  int n_checks = 0;
  int n_errors = 0;

  obs_t q0[$];
  obs_t q1[$];

  // Behavioural model: a PC, a count of invalid cycles still owed, and flags.
  logic [31:0] m_pc[2];
  logic [31:0] m_addr[2];
  bit          m_err[2];
  bit          m_halted[2];
  bit          m_boot[2];
  int          m_left[2];

  always #5 clk = ~clk;

  pc_sequencer #(.BITSIZE(32), .RESET_VECTOR(32'h0000_0000), .C_EXT(1'b1), .BUBBLE_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .Stall(stall), .Compressed(comp), .BranchTaken(bt),
    .BranchTarget(target), .Trap(trap), .TrapVector(tv), .Halt(halt),
    .PC(pc_c), .PCnext(pcn_c), .PCvalid(v_c), .MisalignedErr(e_c), .MisalignedAddr(a_c)
  );

  pc_sequencer #(.BITSIZE(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b0), .BUBBLE_CYCLES(3)) dut_n (
    .clk(clk), .rst(rst), .Stall(stall), .Compressed(comp), .BranchTaken(bt),
    .BranchTarget(target), .Trap(trap), .TrapVector(tv), .Halt(halt),
    .PC(pc_n), .PCnext(pcn_n), .PCvalid(v_n), .MisalignedErr(e_n), .MisalignedAddr(a_n)
  );

  function automatic logic [31:0] rv(int k);
    return (k == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic int bc(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] step(int k, logic c);
    return (k == 0 && c) ? 32'd2 : 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_pc[k] = rv(k); m_addr[k] = '0; m_err[k] = 0;
    m_halted[k] = 0; m_boot[k] = 1; m_left[k] = 0;
  endtask

  task automatic model_step(input int k);
    logic [31:0] tva;
    bit          mis;
    tva = tv & 32'hFFFF_FFFC;
    m_err[k] = 0;
    if (m_boot[k]) begin
      m_boot[k] = 0;
      m_pc[k] = rv(k);
    end else if (m_halted[k]) begin
      if (trap) m_pc[k] = tva;
      else if (!halt) begin m_halted[k] = 0; m_left[k] = bc(k); end
    end else if (trap) begin
      m_pc[k] = tva; m_left[k] = bc(k); m_halted[k] = halt;
    end else if (halt) begin
      m_halted[k] = 1;
    end else if (bt) begin
      mis = target[0] || (k == 1 && target[1]);
      if (mis) begin m_pc[k] = tva; m_err[k] = 1; m_addr[k] = target; end
      else m_pc[k] = target;
      m_left[k] = bc(k);
    end else if (m_left[k] > 0) begin
      m_left[k]--;
    end else if (!stall) begin
      m_pc[k] = m_pc[k] + step(k, comp);
    end
  endtask

  function automatic obs_t expect_of(int k);
    obs_t o;
    o.pc   = m_pc[k];
    o.pcn  = m_pc[k] + step(k, comp);
    o.v    = !m_boot[k] && !m_halted[k] && (m_left[k] == 0);
    o.e    = m_err[k];
    o.addr = m_addr[k];
    return o;
  endfunction

  task automatic drive(input logic r, input logic s, input logic c, input logic b,
                       input logic [31:0] tg, input logic t, input logic [31:0] v,
                       input logic h);
    @(negedge clk);
    rst = r; stall = s; comp = c; bt = b; target = tg; trap = t; tv = v; halt = h;
    for (int k = 0; k < 2; k++) begin
      if (r) model_reset(k);
      else model_step(k);
    end
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic compare(input string tag, input obs_t a, input obs_t e);
    check({tag, ".PC"}, a.pc, e.pc);
    check({tag, ".PCnext"}, a.pcn, e.pcn);
    check({tag, ".PCvalid"}, a.v, e.v);
    check({tag, ".MisalignedErr"}, a.e, e.e);
    check({tag, ".MisalignedAddr"}, a.addr, e.addr);
  endtask

  // Monitor: one expectation per DUT per clock, compared after the edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = '{pc_c, pcn_c, v_c, e_c, a_c};
        compare("cext", a, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = '{pc_n, pcn_n, v_n, e_n, a_n};
        compare("nocext", a, e);
      end
    end
  end

  initial begin
    logic        r, s, c, b, t, h;
    logic [31:0] tg, v;
    int          halt_left;
    halt_left = 0;

    #2 rst = 1'b1;
    #1;
    check("async_reset.cext.PC", pc_c, 32'h0000_0000);
    check("async_reset.nocext.PC", pc_n, 32'h0000_1000);
    check("async_reset.cext.PCvalid", v_c, 1'b0);
    check("async_reset.nocext.MisalignedAddr", a_n, 32'h0);

    // Reset then free run.
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    idle(4);
    // Compressed steps from 0x10.
    drive(0, 0, 0, 1, 32'h10, 0, 32'h0, 0);
    idle(3);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 0);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 0);
    idle(1);
    // Branch under stall.
    drive(0, 1, 0, 1, 32'h100, 0, 32'h0, 0);
    idle(4);
    // Misaligned target.
    drive(0, 0, 0, 1, 32'h203, 0, 32'h80, 0);
    @(posedge clk);
    #1;
    check("misaligned.cext.err", e_c, 1'b1);
    check("misaligned.cext.addr", a_c, 32'h203);
    check("misaligned.cext.PC", pc_c, 32'h80);
    check("misaligned.nocext.PC", pc_n, 32'h80);
    // Back-to-back: 0x102 is misaligned only without compressed support.
    drive(0, 0, 0, 1, 32'h102, 0, 32'h80, 0);
    idle(5);
    // Trap wins over branch, then a 3-cycle halt.
    drive(0, 0, 0, 1, 32'h200, 1, 32'h43, 0);
    idle(1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    idle(6);
    // Wrap at the top of the address space.
    drive(0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0, 0);
    idle(6);
    // Reset in the middle of a bubble.
    drive(0, 0, 0, 1, 32'h300, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    check("bubble_reset.cext.PC", pc_c, 32'h0000_0000);
    check("bubble_reset.nocext.PC", pc_n, 32'h0000_1000);
    check("bubble_reset.cext.PCvalid", v_c, 1'b0);
    check("bubble_reset.nocext.PCvalid", v_n, 1'b0);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 3) == 0);
      c = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 15) == 0);
      if (halt_left == 0 && $urandom_range(0, 40) == 0) halt_left = $urandom_range(1, 4);
      h = (halt_left > 0);
      if (halt_left > 0) halt_left--;
      tg = $urandom;
      if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
      v = $urandom;
      drive(r, s, c, b, tg, t, v, h);
    end

    idle(1);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
